// File: rtl/avalon_timer_pkg.sv
// Shared register offsets and bit positions for the multi-channel Avalon interval timer.
package avalon_timer_pkg;

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIOD  = 3'd2;
  localparam logic [2:0] REG_SNAP    = 3'd3;
  localparam logic [2:0] REG_COUNT   = 3'd4;

  localparam int STATUS_TO  = 0;
  localparam int STATUS_RUN = 1;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: down-counter with PERIOD reload, SNAP capture, CONTROL bits,
// RUN/TO status and a one-clock timeout pulse.
module timer_channel
  import avalon_timer_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter logic [31:0] RESET_PERIOD = 32'h1E847
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             wr_en,
  input  logic [2:0]       wr_reg,
  input  logic [CNT_W-1:0] wr_data,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] snap,
  output logic             run,
  output logic             to,
  output logic             cont,
  output logic             ito,
  output logic             tout
);

  localparam logic [CNT_W-1:0] RST_VAL = RESET_PERIOD[CNT_W-1:0];

  logic reload_pend;
  logic wr_status, wr_control, wr_period, wr_snap;
  logic start, stop, active, expire;

  assign wr_status  = wr_en && (wr_reg == REG_STATUS);
  assign wr_control = wr_en && (wr_reg == REG_CONTROL);
  assign wr_period  = wr_en && (wr_reg == REG_PERIOD);
  assign wr_snap    = wr_en && (wr_reg == REG_SNAP);
  assign start      = wr_control && wr_data[CTRL_START];
  assign stop       = wr_control && wr_data[CTRL_STOP];

  // Counting pauses in the PERIOD write cycle and the reload cycle after it,
  // so a forced reload can never produce a timeout.
  assign active = run && tick && !reload_pend && !wr_period;
  assign expire = active && (count == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= RST_VAL;
      period      <= RST_VAL;
      snap        <= '0;
      run         <= 1'b0;
      to          <= 1'b0;
      cont        <= 1'b0;
      ito         <= 1'b0;
      tout        <= 1'b0;
      reload_pend <= 1'b0;
    end else begin
      reload_pend <= wr_period;
      tout        <= expire;
      if (wr_period) period <= wr_data;
      if (wr_control) begin
        cont <= wr_data[CTRL_CONT];
        ito  <= wr_data[CTRL_ITO];
      end
      if (wr_snap) snap <= count;

      if (reload_pend || expire) count <= period;
      else if (active)           count <= count - CNT_W'(1);

      // START beats STOP, a forced reload and a one-shot expiry.
      if (start)                                     run <= 1'b1;
      else if (reload_pend || stop || (expire && !cont)) run <= 1'b0;

      if (expire)         to <= 1'b1;
      else if (wr_status) to <= 1'b0;
    end
  end

endmodule

// File: rtl/avalon_multi_timer.sv
// Multi-channel interval timer: shared prescaler, NUM_CH timer_channel instances,
// Avalon-MM register decode with a registered read port and an OR-ed interrupt.
module avalon_multi_timer
  import avalon_timer_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter int          PRESCALE     = 1,
  parameter logic [31:0] RESET_PERIOD = 32'h1E847,
  localparam int         CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int         ADDR_W       = CH_W + 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec,
  output logic [NUM_CH-1:0] tout
);

  // Avalon-MM slave handshake: every clk edge with chipselect high is one transfer
  // (no waitrequest); write_n low writes writedata, write_n high reads and readdata
  // holds the addressed value from the following cycle on.

  logic tick;

  generate
    if (PRESCALE == 1) begin : g_no_presc
      assign tick = 1'b1;
    end else begin : g_presc
      localparam int PW = $clog2(PRESCALE);
      logic [PW-1:0] presc;
      assign tick = (presc == PW'(PRESCALE - 1));
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + PW'(1);
      end
    end
  endgenerate

  logic [CH_W-1:0] ch_idx;
  logic [2:0]      reg_idx;
  logic            wr_req, rd_req;

  assign ch_idx  = address[ADDR_W-1:3];
  assign reg_idx = address[2:0];
  assign wr_req  = chipselect && !write_n;
  assign rd_req  = chipselect && write_n;

  logic [CNT_W-1:0]  ch_count  [NUM_CH];
  logic [CNT_W-1:0]  ch_period [NUM_CH];
  logic [CNT_W-1:0]  ch_snap   [NUM_CH];
  logic [NUM_CH-1:0] ch_run, ch_to, ch_cont, ch_ito;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      timer_channel #(
        .CNT_W        (CNT_W),
        .RESET_PERIOD (RESET_PERIOD)
      ) u_ch (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .wr_en   (wr_req && (ch_idx == CH_W'(i))),
        .wr_reg  (reg_idx),
        .wr_data (writedata[CNT_W-1:0]),
        .count   (ch_count[i]),
        .period  (ch_period[i]),
        .snap    (ch_snap[i]),
        .run     (ch_run[i]),
        .to      (ch_to[i]),
        .cont    (ch_cont[i]),
        .ito     (ch_ito[i]),
        .tout    (tout[i])
      );
    end
  endgenerate

  assign irq_vec = ch_to & ch_ito;
  assign irq     = |irq_vec;

  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    if (int'(ch_idx) < NUM_CH) begin
      case (reg_idx)
        REG_STATUS: begin
          rd_val[STATUS_RUN] = ch_run[ch_idx];
          rd_val[STATUS_TO]  = ch_to[ch_idx];
        end
        REG_CONTROL: begin
          rd_val[CTRL_CONT] = ch_cont[ch_idx];
          rd_val[CTRL_ITO]  = ch_ito[ch_idx];
        end
        REG_PERIOD: rd_val[CNT_W-1:0] = ch_period[ch_idx];
        REG_SNAP:   rd_val[CNT_W-1:0] = ch_snap[ch_idx];
        REG_COUNT:  rd_val[CNT_W-1:0] = ch_count[ch_idx];
        default:    rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    readdata <= '0;
    else if (rd_req) readdata <= rd_val;
  end

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Bench for avalon_multi_timer: register-map vector table plus timed sequences
// on a PRESCALE=1 instance (dut1) and a PRESCALE=4, 16-bit, 5-channel instance (dut4).
module tb_avalon_multi_timer;
  import avalon_timer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [5:0]  address = '0;
  logic        cs1 = 1'b0, cs4 = 1'b0, write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] rd1, rd4;
  logic        irq1, irq4;
  logic [3:0]  irq_vec1, tout1;
  logic [4:0]  irq_vec4, tout4;

  avalon_multi_timer #(.NUM_CH(4), .CNT_W(32), .PRESCALE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address[4:0]), .chipselect(cs1),
    .write_n(write_n), .writedata(writedata), .readdata(rd1), .irq(irq1),
    .irq_vec(irq_vec1), .tout(tout1)
  );

  avalon_multi_timer #(.NUM_CH(5), .CNT_W(16), .PRESCALE(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs4),
    .write_n(write_n), .writedata(writedata), .readdata(rd4), .irq(irq4),
    .irq_vec(irq_vec4), .tout(tout4)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  int t1_0[$], t1_1[$], t1_2[$], t4_0[$];
  int t4_1_cnt = 0;

  always @(negedge clk) begin
    if (tout1[0]) t1_0.push_back(cyc);
    if (tout1[1]) t1_1.push_back(cyc);
    if (tout1[2]) t1_2.push_back(cyc);
    if (tout4[0]) t4_0.push_back(cyc);
    if (tout4[1]) t4_1_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [5:0] reg_addr(input int ch, input logic [2:0] r);
    return {3'(ch), r};
  endfunction

  // Called at a negedge; the write lands on the next posedge.
  task automatic drive_write(input logic sel4, input logic [5:0] a, input logic [31:0] d);
    address = a; writedata = d; write_n = 1'b0;
    cs1 = !sel4; cs4 = sel4;
    @(negedge clk);
    cs1 = 1'b0; cs4 = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_write(input logic sel4, input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    drive_write(sel4, a, d);
  endtask

  task automatic bus_read(input logic sel4, input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; write_n = 1'b1;
    cs1 = !sel4; cs4 = sel4;
    @(negedge clk);
    cs1 = 1'b0; cs4 = 1'b0;
    d = sel4 ? rd4 : rd1;
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("wait_cyc", cyc, target);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        sel4;
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  localparam int N_VEC   = 22;
  localparam int N_RESET = 8;
  vec_t vecs[N_VEC];

  task automatic run_vecs(input int n);
    logic [31:0] rd;
    for (int i = 0; i < n; i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].sel4, vecs[i].addr, vecs[i].data);
      end else begin
        exp_q.push_back(vecs[i].exp);
        bus_read(vecs[i].sel4, vecs[i].addr, rd);
        check($sformatf("vec%0d", i), rd, exp_q.pop_front());
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, r, x;
    logic [31:0] rd;

    // Reset-value reads first; later entries exercise register write/read rules.
    vecs[0]  = '{1'b0, 1'b0, reg_addr(0, REG_STATUS),  32'h0,     32'h0};
    vecs[1]  = '{1'b0, 1'b0, reg_addr(0, REG_CONTROL), 32'h0,     32'h0};
    vecs[2]  = '{1'b0, 1'b0, reg_addr(0, REG_PERIOD),  32'h0,     32'h1E847};
    vecs[3]  = '{1'b0, 1'b0, reg_addr(3, REG_COUNT),   32'h0,     32'h1E847};
    vecs[4]  = '{1'b0, 1'b0, reg_addr(3, REG_SNAP),    32'h0,     32'h0};
    vecs[5]  = '{1'b0, 1'b0, reg_addr(2, 3'd5),        32'h0,     32'h0};
    vecs[6]  = '{1'b1, 1'b0, reg_addr(0, REG_PERIOD),  32'h0,     32'hE847};
    vecs[7]  = '{1'b1, 1'b0, reg_addr(4, REG_COUNT),   32'h0,     32'hE847};
    vecs[8]  = '{1'b0, 1'b1, reg_addr(1, REG_CONTROL), 32'h3,     32'h0};
    vecs[9]  = '{1'b0, 1'b0, reg_addr(1, REG_CONTROL), 32'h0,     32'h3};
    vecs[10] = '{1'b0, 1'b1, reg_addr(1, REG_CONTROL), 32'h0,     32'h0};
    vecs[11] = '{1'b1, 1'b1, reg_addr(1, REG_PERIOD),  32'h12345, 32'h0};
    vecs[12] = '{1'b1, 1'b0, reg_addr(1, REG_PERIOD),  32'h0,     32'h2345};
    vecs[13] = '{1'b1, 1'b0, reg_addr(1, REG_COUNT),   32'h0,     32'h2345};
    vecs[14] = '{1'b1, 1'b1, reg_addr(5, REG_PERIOD),  32'h7,     32'h0};
    vecs[15] = '{1'b1, 1'b0, reg_addr(5, REG_PERIOD),  32'h0,     32'h0};
    vecs[16] = '{1'b0, 1'b1, reg_addr(0, 3'd6),        32'hFFFF,  32'h0};
    vecs[17] = '{1'b0, 1'b0, reg_addr(0, 3'd6),        32'h0,     32'h0};
    vecs[18] = '{1'b0, 1'b1, reg_addr(0, REG_COUNT),   32'h77,    32'h0};
    vecs[19] = '{1'b0, 1'b0, reg_addr(0, REG_COUNT),   32'h0,     32'h1E847};
    vecs[20] = '{1'b0, 1'b1, reg_addr(0, REG_CONTROL), 32'h8,     32'h0};
    vecs[21] = '{1'b0, 1'b0, reg_addr(0, REG_CONTROL), 32'h0,     32'h0};

    repeat (3) @(negedge clk);
    check("rst_readdata", rd1, 32'h0);
    check("rst_tout", {tout4, tout1}, 32'h0);
    check("rst_irq", {irq4, irq1, irq_vec4, irq_vec1}, 32'h0);
    reset_n = 1'b1;

    run_vecs(N_VEC);

    // Continuous PERIOD=3: a timeout every 4 clocks, irq only once ITO is set.
    bus_write(1'b0, reg_addr(0, REG_PERIOD), 32'd3);
    t1_0.delete();
    bus_write(1'b0, reg_addr(0, REG_CONTROL), 32'h6);
    s = cyc;
    wait_cyc(s + 17);
    check("t1_tout_count", t1_0.size(), 4);
    if (t1_0.size() > 0) check("t1_first_tout", t1_0[0], s + 4);
    for (int i = 1; i < t1_0.size(); i++) check("t1_tout_spacing", t1_0[i] - t1_0[i-1], 4);
    bus_read(1'b0, reg_addr(0, REG_STATUS), rd);
    check("t1_status", rd, 32'h3);
    check("t1_irq_masked", irq1, 1'b0);
    bus_write(1'b0, reg_addr(0, REG_CONTROL), 32'h3);
    check("t1_irq", irq1, 1'b1);
    check("t1_irq_vec", irq_vec1, 4'b0001);
    bus_write(1'b0, reg_addr(0, REG_CONTROL), 32'hB);
    bus_read(1'b0, reg_addr(0, REG_STATUS), rd);
    check("t1_stopped_status", rd, 32'h1);
    bus_write(1'b0, reg_addr(0, REG_STATUS), 32'h0);
    bus_read(1'b0, reg_addr(0, REG_STATUS), rd);
    check("t1_to_cleared", rd, 32'h0);
    check("t1_irq_cleared", irq1, 1'b0);

    // One-shot PERIOD=5: exactly one timeout, 6 ticks after START.
    bus_write(1'b0, reg_addr(1, REG_PERIOD), 32'd5);
    t1_1.delete();
    bus_write(1'b0, reg_addr(1, REG_CONTROL), 32'h4);
    s = cyc;
    wait_cyc(s + 20);
    check("t2_tout_count", t1_1.size(), 1);
    if (t1_1.size() > 0) check("t2_tout_time", t1_1[0], s + 6);
    bus_read(1'b0, reg_addr(1, REG_STATUS), rd);
    check("t2_status", rd, 32'h1);
    bus_read(1'b0, reg_addr(1, REG_COUNT), rd);
    check("t2_count", rd, 32'd5);

    // PRESCALE=4, PERIOD=2, continuous: a timeout every 12 clocks, ch1 silent.
    bus_write(1'b1, reg_addr(0, REG_PERIOD), 32'd2);
    t4_0.delete();
    t4_1_cnt = 0;
    bus_write(1'b1, reg_addr(0, REG_CONTROL), 32'h6);
    s = cyc;
    wait_cyc(s + 58);
    check("t3_tout_count", t4_0.size() >= 4, 1'b1);
    if (t4_0.size() > 0) check("t3_first_phase", (t4_0[0] - s) inside {[9:12]}, 1'b1);
    for (int i = 1; i < t4_0.size(); i++) check("t3_tout_spacing", t4_0[i] - t4_0[i-1], 12);
    check("t3_idle_channel", t4_1_cnt, 0);

    // STATUS write landing on the timeout edge must leave TO set.
    bus_write(1'b0, reg_addr(2, REG_PERIOD), 32'd3);
    t1_2.delete();
    bus_write(1'b0, reg_addr(2, REG_CONTROL), 32'h6);
    s = cyc;
    wait_cyc(s + 7);
    drive_write(1'b0, reg_addr(2, REG_STATUS), 32'h0);
    check("t4_tout_coincide", tout1[2], 1'b1);
    bus_read(1'b0, reg_addr(2, REG_STATUS), rd);
    check("t4_to_kept", rd, 32'h3);
    wait_cyc(s + 12);
    drive_write(1'b0, reg_addr(2, REG_STATUS), 32'h0);
    bus_read(1'b0, reg_addr(2, REG_STATUS), rd);
    check("t4_to_cleared", rd, 32'h2);

    // PERIOD write on a running channel stops it and reloads; START wins over STOP.
    bus_write(1'b0, reg_addr(2, REG_PERIOD), 32'h10);
    bus_read(1'b0, reg_addr(2, REG_STATUS), rd);
    check("t5_run_cleared", rd[STATUS_RUN], 1'b0);
    bus_read(1'b0, reg_addr(2, REG_COUNT), rd);
    check("t5_count_reload", rd, 32'h10);
    bus_write(1'b0, reg_addr(2, REG_CONTROL), 32'hC);
    bus_read(1'b0, reg_addr(2, REG_STATUS), rd);
    check("t5_start_over_stop", rd[STATUS_RUN], 1'b1);
    @(negedge clk);
    drive_write(1'b0, reg_addr(2, REG_PERIOD), 32'h10);
    drive_write(1'b0, reg_addr(2, REG_CONTROL), 32'h4);
    r = cyc;
    bus_read(1'b0, reg_addr(2, REG_STATUS), rd);
    check("t5_start_over_reload", rd[STATUS_RUN], 1'b1);
    wait_cyc(r + 4);
    drive_write(1'b0, reg_addr(2, REG_CONTROL), 32'h8);
    bus_read(1'b0, reg_addr(2, REG_COUNT), rd);
    check("t5_stop_count", rd, 32'hB);
    repeat (5) @(negedge clk);
    bus_read(1'b0, reg_addr(2, REG_COUNT), rd);
    check("t5_count_held", rd, 32'hB);
    t1_2.delete();
    bus_write(1'b0, reg_addr(2, REG_CONTROL), 32'h4);
    x = cyc;
    wait_cyc(x + 15);
    check("t5_resume_tout_count", t1_2.size(), 1);
    if (t1_2.size() > 0) check("t5_resume_tout_time", t1_2[0], x + 12);

    // SNAP captures the live count at the write edge; reset mid-count clears everything.
    bus_write(1'b0, reg_addr(3, REG_PERIOD), 32'd100);
    bus_write(1'b0, reg_addr(3, REG_CONTROL), 32'h4);
    s = cyc;
    wait_cyc(s + 9);
    drive_write(1'b0, reg_addr(3, REG_SNAP), 32'h0);
    bus_read(1'b0, reg_addr(3, REG_SNAP), rd);
    check("t6_snap", rd, 32'd91);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("t6_rst_readdata", rd1, 32'h0);
    check("t6_rst_tout_irq", {tout4, tout1, irq_vec4, irq_vec1, irq4, irq1}, 32'h0);
    reset_n = 1'b1;
    run_vecs(N_RESET);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
